// File: rtl/adc_frame_rx.sv
// adc_frame_rx: MSB-first serial ADC frame receiver, all logic on falling dclk.
// Define ADC_CRC_EN to expect and verify a trailing CRC-8 (poly 0x07, init 0x00).
module adc_frame_rx #(
  parameter int DATA_BITS = 24,
  parameter int SAMPLES_PER_PERIOD = 8
) (
  input  logic                 dclk,
  input  logic                 rst_dclk_n,
  input  logic                 drdy,
  input  logic                 dout,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] sample_data,
  output logic [2:0]           sample_idx,
  output logic                 sample_tog,
  output logic                 clip,
  output logic                 ovr_sticky,
  output logic                 crc_err_sticky,
  output logic                 busy
);
  localparam int CW = $clog2(DATA_BITS + 8);
`ifdef ADC_CRC_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CRC} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state, state_nx;
  logic drdy_q, rise, done, done_nx, crc_ok;
  logic [CW-1:0] cnt;
  logic [DATA_BITS-1:0] sr;
  assign rise = drdy & ~drdy_q;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    case (state)
      IDLE: if (rise) state_nx = SHIFT;
      SHIFT: if (cnt == CW'(DATA_BITS - 1)) begin
`ifdef ADC_CRC_EN
        state_nx = CRC;
`else
        state_nx = IDLE;
        done_nx = 1'b1;
`endif
      end
`ifdef ADC_CRC_EN
      CRC: if (cnt == CW'(7)) begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end
  // Completed frames publish one edge after the FSM returns to IDLE.
  always_ff @(negedge dclk or negedge rst_dclk_n)
    if (!rst_dclk_n) begin
      state <= IDLE;
      drdy_q <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      sr <= '0;
      sample_data <= '0;
      sample_idx <= '0;
      sample_tog <= 1'b0;
      clip <= 1'b0;
      ovr_sticky <= 1'b0;
    end else begin
      state <= state_nx;
      drdy_q <= drdy;
      done <= done_nx;
      cnt <= (state == IDLE || state_nx != state) ? '0 : cnt + CW'(1);
      if (state == SHIFT) sr <= {sr[DATA_BITS-2:0], dout};
      ovr_sticky <= (busy & rise) | (ovr_sticky & ~ovr_clr);
      if (done) begin
        sample_tog <= ~sample_tog;
        sample_idx <= (sample_idx == 3'(SAMPLES_PER_PERIOD - 1)) ? '0 : sample_idx + 3'd1;
        if (crc_ok) begin
          sample_data <= sr;
          clip <= (sr == {1'b0, {(DATA_BITS-1){1'b1}}}) || (sr == {1'b1, {(DATA_BITS-1){1'b0}}});
        end
      end
    end
`ifdef ADC_CRC_EN
  logic [7:0] crc_calc, crc_rx;
  assign crc_ok = crc_calc == crc_rx;
  // Both CRC registers are still valid on the publish edge and clear afterwards.
  always_ff @(negedge dclk or negedge rst_dclk_n)
    if (!rst_dclk_n) begin
      crc_calc <= '0;
      crc_rx <= '0;
      crc_err_sticky <= 1'b0;
    end else begin
      if (state == IDLE) begin
        crc_calc <= '0;
        crc_rx <= '0;
      end
      if (state == SHIFT) crc_calc <= {crc_calc[6:0], 1'b0} ^ ((crc_calc[7] ^ dout) ? 8'h07 : 8'h00);
      if (state == CRC) crc_rx <= {crc_rx[6:0], dout};
      crc_err_sticky <= (done & ~crc_ok) | (crc_err_sticky & ~ovr_clr);
    end
`else
  assign crc_ok = 1'b1;
  assign crc_err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_adc_frame_rx.sv
// tb_adc_frame_rx: vector table, random frames and corner sequences against a frame-level model.
module tb_adc_frame_rx;
  localparam int DB = 24, SPP = 8;
`ifdef ADC_CRC_EN
  localparam int FL = DB + 8;
`else
  localparam int FL = DB;
`endif
  typedef struct {
    logic [DB-1:0] d;
    int ovr_at;
    bit clr;
    logic exp_clip;
    logic exp_ovr;
  } vec_t;
  logic dclk = 0, rst_dclk_n = 0, drdy = 0, dout = 0, ovr_clr = 0;
  logic [DB-1:0] sample_data;
  logic [2:0] sample_idx;
  logic sample_tog, clip, ovr_sticky, crc_err_sticky, busy;
  int errors = 0, checks = 0;
  int n_frames = 0;
  logic [DB-1:0] m_data = '0;
  logic m_ovr = 0, m_crc = 0;

  adc_frame_rx dut (
    .dclk(dclk), .rst_dclk_n(rst_dclk_n), .drdy(drdy), .dout(dout), .ovr_clr(ovr_clr),
    .sample_data(sample_data), .sample_idx(sample_idx), .sample_tog(sample_tog), .clip(clip),
    .ovr_sticky(ovr_sticky), .crc_err_sticky(crc_err_sticky), .busy(busy)
  );

  always #5 dclk = ~dclk;

  function automatic bit is_clip(input logic [DB-1:0] d);
    return d == DB'((1 << (DB - 1)) - 1) || d == DB'(1 << (DB - 1));
  endfunction

`ifdef ADC_CRC_EN
  function automatic logic [7:0] crc8(input logic [DB-1:0] d);
    logic [DB+7:0] m;
    m = {d, 8'h00};
    for (int b = DB + 7; b >= 8; b--) if (m[b]) m = m ^ ((DB+8)'(9'h107) << (b - 8));
    return m[7:0];
  endfunction
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " data"}, 32'(sample_data), 32'(m_data));
    chk({tag, " idx"}, 32'(sample_idx), 32'(n_frames % SPP));
    chk({tag, " tog"}, 32'(sample_tog), 32'(n_frames % 2));
    chk({tag, " clip"}, 32'(clip), 32'(is_clip(m_data)));
    chk({tag, " ovr"}, 32'(ovr_sticky), 32'(m_ovr));
    chk({tag, " crc_err"}, 32'(crc_err_sticky), 32'(m_crc));
    chk({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Sends one frame; drdy drops at bit 2 and may rise again at ovr_at; stop_at aborts before that bit.
  task automatic frame(input logic [DB-1:0] d, input int ovr_at, input int stop_at, input bit bad,
                       input bit pre, input bit clr);
    logic [FL-1:0] bits;
`ifdef ADC_CRC_EN
    bits = {d, crc8(d) ^ (bad ? 8'hFF : 8'h00)};
`else
    bits = d;
`endif
    if (!pre) begin
      @(posedge dclk);
      drdy = 1;
    end
    for (int i = 0; i < FL; i++) begin
      @(posedge dclk);
      if (i == stop_at) return;
      dout = bits[FL-1-i];
      if (i == 2) drdy = 0;
      ovr_clr = clr && i == ovr_at;
      if (i == ovr_at) drdy = 1;
    end
    @(posedge dclk);
    ovr_clr = 0;
    @(posedge dclk);
  endtask

  task automatic model_frame(input logic [DB-1:0] d, input bit ovr, input bit bad);
    n_frames++;
    if (bad) m_crc = 1;
    else m_data = d;
    if (ovr) m_ovr = 1;
  endtask

  task automatic settle_and_clear(input string tag);
    int tog0;
    tog0 = sample_tog;
    repeat (40) @(posedge dclk);
    chk({tag, " level-high no frame"}, 32'(sample_tog), 32'(tog0));
    chk({tag, " level-high idle"}, 32'(busy), 32'd0);
    drdy = 0;
    ovr_clr = 1;
    @(posedge dclk);
    ovr_clr = 0;
    @(posedge dclk);
    m_ovr = 0;
    m_crc = 0;
    chk({tag, " ovr cleared"}, 32'(ovr_sticky), 32'd0);
  endtask

  initial begin
    vec_t tbl[8];
    logic [DB-1:0] d;
    int o;
    tbl = '{
      '{24'h123456, -1, 0, 0, 0},
      '{24'h7FFFFF, -1, 0, 1, 0},
      '{24'h800000, -1, 0, 1, 0},
      '{24'h000001, -1, 0, 0, 0},
      '{24'hFFFFFF, -1, 0, 0, 0},
      '{24'h000000, -1, 0, 0, 0},
      '{24'hABCDEF, 10, 0, 0, 1},
      '{24'h555555, 12, 1, 0, 1}
    };
    repeat (3) @(posedge dclk);
    chk_all("reset");
    rst_dclk_n = 1;
    foreach (tbl[k]) begin
      frame(tbl[k].d, tbl[k].ovr_at, -1, 0, 0, tbl[k].clr);
      model_frame(tbl[k].d, tbl[k].ovr_at >= 0, 0);
      chk($sformatf("vec%0d data", k), 32'(sample_data), 32'(tbl[k].d));
      chk($sformatf("vec%0d clip", k), 32'(clip), 32'(tbl[k].exp_clip));
      chk($sformatf("vec%0d ovr", k), 32'(ovr_sticky), 32'(tbl[k].exp_ovr));
      chk_all($sformatf("vec%0d", k));
      if (tbl[k].ovr_at >= 0) settle_and_clear($sformatf("vec%0d", k));
    end
    for (int r = 0; r < 14; r++) begin
      d = DB'($urandom);
      if ($urandom_range(0, 5) == 0) d = $urandom_range(0, 1) ? 24'h7FFFFF : 24'h800000;
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 20)) : -1;
      frame(d, o, -1, 0, 0, 0);
      model_frame(d, o >= 0, 0);
      chk_all($sformatf("rnd%0d", r));
      if (o >= 0) settle_and_clear($sformatf("rnd%0d", r));
    end
    frame(24'h13579B, -1, 12, 0, 0, 0);
    chk("midframe busy", 32'(busy), 32'd1);
    rst_dclk_n = 0;
    drdy = 1;
    n_frames = 0;
    m_data = '0;
    m_ovr = 0;
    m_crc = 0;
    repeat (2) @(posedge dclk);
    chk_all("midreset");
    repeat (30) @(posedge dclk);
    chk_all("partial discarded");
    rst_dclk_n = 1;
    frame(24'hABCDEF, -1, -1, 0, 1, 0);
    model_frame(24'hABCDEF, 0, 0);
    chk("post-reset data", 32'(sample_data), 32'hABCDEF);
    chk("post-reset idx", 32'(sample_idx), 32'd1);
    chk_all("post-reset");
`ifdef ADC_CRC_EN
    frame(24'h000001, -1, -1, 0, 0, 0);
    model_frame(24'h000001, 0, 0);
    chk("crc good data", 32'(sample_data), 32'h000001);
    chk_all("crc good");
    frame(24'h123456, -1, -1, 0, 0, 0);
    model_frame(24'h123456, 0, 0);
    frame(24'h000001, -1, -1, 1, 0, 0);
    model_frame(24'h000001, 0, 1);
    chk("crc bad err", 32'(crc_err_sticky), 32'd1);
    chk("crc bad data held", 32'(sample_data), 32'h123456);
    chk_all("crc bad");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
